// File: rtl/skid_buffer_pkg.sv
// Shared pipeline package: decoded-instruction packet type and the skid buffer
// state encoding used between the decoder and the executor.
//
// Contents:
//   DECODED_PKT_WIDTH - width of one decoded-instruction packet
//   decoded_pkt_t     - decoded-instruction packet
//   skid_state_e      - skid buffer occupancy state

package skid_buffer_pkg;

  localparam int unsigned DECODED_PKT_WIDTH = 64;

  typedef logic [DECODED_PKT_WIDTH-1:0] decoded_pkt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,  // no entries
    SKID_BUSY  = 2'd1,  // main register valid
    SKID_FULL  = 2'd2   // main and skid registers valid
  } skid_state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer between the decoder and the executor. Both in_ready
// and out_valid come straight from flops, so there is no combinational path
// from out_ready back to in_ready, yet one transfer per cycle is sustained.
//
// Optional feature: define SKID_BUFFER_STATS_EN to add the stall_cycles output
// (saturating count of cycles with out_valid && !out_ready, cleared by reset).
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - synchronous, active-high; highest priority
//   flush        - synchronous pipeline flush; drops all entries
//   in_valid     - producer offers in_data
//   in_data      - producer payload
//   in_ready     - buffer accepts in_data this cycle
//   out_valid    - out_data holds a valid entry
//   out_data     - head entry (always the main register)
//   out_ready    - consumer takes out_data this cycle
//   stall_cycles - (SKID_BUFFER_STATS_EN only) stall cycle counter

module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DECODED_PKT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             in_hs, out_hs;

  assign in_hs  = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      SKID_EMPTY: begin
        if (in_hs) begin
          main_d  = in_data;
          state_d = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_hs && out_hs) begin
          main_d = in_data;
        end else if (in_hs) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (out_hs) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_hs) begin
          main_d  = skid_q;
          state_d = SKID_BUSY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase

    // Flush/reset drop everything in flight; data registers keep their old
    // contents so a dropped entry never reaches out_data.
    if (reset || flush) begin
      state_d = SKID_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    in_ready_d  = (state_d != SKID_FULL);
    out_valid_d = (state_d != SKID_EMPTY);
  end

`ifdef SKID_BUFFER_STATS_EN
  logic [31:0] stall_q;
`endif

  always_ff @(posedge clock) begin
    // Payload registers are never cleared; only validity is.
    main_q <= main_d;
    skid_q <= skid_d;
    if (reset) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SKID_BUFFER_STATS_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SKID_BUFFER_STATS_EN
      if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef SKID_BUFFER_STATS_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed self-checking bench for skid_buffer. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, well away from the edge.

module tb_skid_buffer;

  localparam int unsigned WIDTH = 64;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef SKID_BUFFER_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  int unsigned n_checks;
  int unsigned n_fails;

  skid_buffer #(
    .WIDTH(WIDTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
`ifdef SKID_BUFFER_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    drive(1'b0, 64'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Single transfer, one-cycle latency
    drive(1'b1, 64'h11, 1'b1);
    tick();
    check_eq("single_out_valid", {63'b0, out_valid}, 64'd1);
    check_eq("single_out_data", out_data, 64'h11);
    check_eq("single_in_ready", {63'b0, in_ready}, 64'd1);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check_eq("single_drain", {63'b0, out_valid}, 64'd0);

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1);
      tick();
      check_eq("stream_out_valid", {63'b0, out_valid}, 64'd1);
      check_eq("stream_out_data", out_data, 64'(i));
      check_eq("stream_in_ready", {63'b0, in_ready}, 64'd1);
    end
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check_eq("stream_drain", {63'b0, out_valid}, 64'd0);

    // Fill to FULL with backpressure, then drain in order
    drive(1'b1, 64'hA, 1'b0);
    tick();
    check_eq("bp_busy_in_ready", {63'b0, in_ready}, 64'd1);
    check_eq("bp_busy_data", out_data, 64'hA);
    drive(1'b1, 64'hB, 1'b0);
    tick();
    check_eq("bp_full_in_ready", {63'b0, in_ready}, 64'd0);
    check_eq("bp_full_out_valid", {63'b0, out_valid}, 64'd1);
    drive(1'b1, 64'hC, 1'b0);
    tick();
    check_eq("bp_held_in_ready", {63'b0, in_ready}, 64'd0);
    check_eq("bp_held_data", out_data, 64'hA);
    drive(1'b1, 64'hC, 1'b1);
    tick();
    check_eq("bp_drain_b", out_data, 64'hB);
    check_eq("bp_drain_b_ready", {63'b0, in_ready}, 64'd1);
    tick();
    check_eq("bp_drain_c", out_data, 64'hC);
    check_eq("bp_drain_c_valid", {63'b0, out_valid}, 64'd1);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check_eq("bp_empty", {63'b0, out_valid}, 64'd0);

    // Flush from FULL while offering 0xC and consuming
    drive(1'b1, 64'hA, 1'b0);
    tick();
    drive(1'b1, 64'hB, 1'b0);
    tick();
    check_eq("fl_full", {63'b0, in_ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 64'hC, 1'b1);
    tick();
    flush = 1'b0;
    check_eq("fl_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("fl_in_ready", {63'b0, in_ready}, 64'd1);
    check_eq("fl_no_c", {63'b0, (out_data == 64'hC)}, 64'd0);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    check_eq("fl_stays_empty", {63'b0, out_valid}, 64'd0);

    // Reset in BUSY with input offered
    drive(1'b1, 64'h21, 1'b0);
    tick();
    check_eq("rb_busy", {63'b0, out_valid}, 64'd1);
    reset = 1'b1;
    drive(1'b1, 64'h22, 1'b0);
    tick();
    reset = 1'b0;
    check_eq("rb_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("rb_in_ready", {63'b0, in_ready}, 64'd1);
    drive(1'b0, 64'h0, 1'b0);
    tick();
    check_eq("rb_after", {63'b0, out_valid}, 64'd0);

    // Reset and flush together in BUSY
    drive(1'b1, 64'h23, 1'b0);
    tick();
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 64'h24, 1'b1);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    check_eq("rf_out_valid", {63'b0, out_valid}, 64'd0);
    check_eq("rf_in_ready", {63'b0, in_ready}, 64'd1);

`ifdef SKID_BUFFER_STATS_EN
    // Stall counter: 5 stalled cycles, survives flush, cleared by reset
    drive(1'b0, 64'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("st_reset", 64'(stall_cycles), 64'd0);
    drive(1'b1, 64'h31, 1'b0);
    tick();
    check_eq("st_loaded", 64'(stall_cycles), 64'd0);
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("st_five", 64'(stall_cycles), 64'd5);
    flush = 1'b1;
    drive(1'b0, 64'h0, 1'b1);
    tick();
    flush = 1'b0;
    check_eq("st_flush", 64'(stall_cycles), 64'd5);
    tick();
    check_eq("st_hold", 64'(stall_cycles), 64'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("st_cleared", 64'(stall_cycles), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: WIDTH, default 64, payload width in bits (decoded-instruction packet width).
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous pipeline flush from control unit.
REQ-005 Port: in_valid  input  1  upstream producer (decoder) offers in_data.
REQ-006 Port: in_data  input  WIDTH  upstream payload.
REQ-007 Port: in_ready  output  1  buffer accepts in_data this cycle.
REQ-008 Port: out_valid  output  1  out_data holds a valid entry for the executor.
REQ-009 Port: out_data  output  WIDTH  head entry.
REQ-010 Port: out_ready  input  1  downstream consumer (executor) takes out_data this cycle.

Function
REQ-011 Transfer rules SHALL be: input handshake = in_valid && in_ready; output handshake = out_valid && out_ready; data SHALL be in-order, never duplicated or dropped except by flush or reset.
REQ-012 State machine SHALL have states EMPTY (no entries), BUSY (main register valid), FULL (main and skid registers valid).
REQ-013 in_ready SHALL be driven directly from a register: 1 in EMPTY/BUSY, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-014 out_valid SHALL be 1 in BUSY/FULL, 0 in EMPTY; out_data SHALL always come from the main register.
REQ-015 EMPTY: input handshake -> main<=in_data, BUSY; otherwise stay.
REQ-016 BUSY: input and output handshake together -> main<=in_data, stay BUSY; input only -> skid<=in_data, FULL; output only -> EMPTY; neither -> stay.
REQ-017 FULL: output handshake -> main<=skid, BUSY; otherwise stay; in_valid ignored.
REQ-018 Latency SHALL be one cycle: an entry accepted at edge N is presented on out_data after edge N; full throughput of one transfer per cycle SHALL be sustained while out_ready stays high.
REQ-019 flush SHALL take priority over every handshake: next state EMPTY, any input offered in the flush cycle dropped, any output handshake in that cycle not counted as delivered.
REQ-020 Data registers SHALL not be cleared by flush or reset; only validity is cleared.

Reset
REQ-021 While reset is high, next state SHALL be EMPTY: out_valid=0, in_ready=1 after the edge; reset mid-transfer discards both entries.
REQ-022 reset SHALL take priority over flush and all handshakes.

Configuration
REQ-023 Macro SKID_BUFFER_STATS_EN SHALL, when defined, add output stall_cycles (32-bit) counting cycles with out_valid && !out_ready, saturating at 0xFFFFFFFF, cleared by reset only (not flush).
REQ-024 Without SKID_BUFFER_STATS_EN the stall_cycles port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-025 The state enum (SKID_EMPTY, SKID_BUSY, SKID_FULL) SHALL live in the shared pipeline package alongside the decoded-packet typedef.
REQ-026 No sub-module; single flat module with one sequential block and one next-state combinational block.

Verification
REQ-027 Reset then in_valid=1, in_data=0x11, out_ready=1 -> out_valid=1, out_data=0x11 one cycle later; in_ready stays 1.
REQ-028 Stream 0x1..0x8 back-to-back with out_ready=1 -> 0x1..0x8 delivered on consecutive cycles, in_ready never drops.
REQ-029 Load 0xA, 0xB with out_ready=0 -> state FULL, in_ready=0, 0xC held off; raise out_ready -> 0xA, 0xB, 0xC delivered in order.
REQ-030 FULL with 0xA/0xB, assert flush with in_valid=1 (0xC) and out_ready=1 -> next cycle out_valid=0, in_ready=1, 0xC never appears.
REQ-031 Reset asserted in BUSY with in_valid=1 -> EMPTY next cycle, no output; reset and flush together -> same result.
REQ-032 With SKID_BUFFER_STATS_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5; flush -> still 5; reset -> 0.
